// File: rtl/mem_pattern_tester_pkg.sv
// rtl/mem_pattern_tester_pkg.sv - shared mode and state encodings for the memory pattern tester
package mem_pattern_tester_pkg;

    localparam logic [1:0] MODE_READ       = 2'd0;
    localparam logic [1:0] MODE_FILL       = 2'd1;
    localparam logic [1:0] MODE_VERIFY     = 2'd2;
    localparam logic [1:0] MODE_INTERLEAVE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/mem_pattern_tester_if.sv
// rtl/mem_pattern_tester_if.sv - single-port memory bus between the tester and a memory
interface mem_pattern_tester_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   ADDR;
    logic [DATA_WIDTH-1:0]   D;
    logic                    WE;
    logic                    RE;
    logic [DATA_WIDTH/8-1:0] BE;
    logic [DATA_WIDTH-1:0]   Q;

    modport master (output ADDR, output D, output WE, output RE, output BE, input Q);
    modport slave  (input ADDR, input D, input WE, input RE, input BE, output Q);
endinterface

// File: rtl/mem_pattern_checker.sv
// rtl/mem_pattern_checker.sv - read-latency aligned compare with saturating error count and first-error capture
module mem_pattern_checker
    import mem_pattern_tester_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int ERR_WIDTH    = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  clear,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] Q,
    output logic [ERR_WIDTH-1:0]  ERR_COUNT,
    output logic [ADDR_WIDTH-1:0] FIRST_ERR_ADDR
);

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
    logic [ADDR_WIDTH-1:0]   pipe_addr [READ_LATENCY];
    logic                    mismatch;

    // Stage READ_LATENCY-1 lines up with the cycle the memory presents Q.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
                pipe_addr[i] <= '0;
            end
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
            end
            pipe_valid[0] <= push_valid;
            pipe_data[0]  <= push_data;
            pipe_addr[0]  <= push_addr;
        end
    end

    assign mismatch = pipe_valid[READ_LATENCY-1] && (Q != pipe_data[READ_LATENCY-1]);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ERR_COUNT      <= '0;
            FIRST_ERR_ADDR <= '0;
        end else if (clear) begin
            ERR_COUNT      <= '0;
            FIRST_ERR_ADDR <= '0;
        end else if (mismatch) begin
            if (ERR_COUNT != '1) begin
                ERR_COUNT <= ERR_COUNT + ERR_WIDTH'(1);
            end
            if (ERR_COUNT == '0) begin
                FIRST_ERR_ADDR <= pipe_addr[READ_LATENCY-1];
            end
        end
    end

endmodule

// File: rtl/mem_pattern_tester.sv
// rtl/mem_pattern_tester.sv - programmable address-sweep traffic generator and pattern checker for one memory port
module mem_pattern_tester
    import mem_pattern_tester_pkg::*;
#(
    parameter int ID           = 0,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16,
    parameter int ERR_WIDTH    = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [1:0]            MODE,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [ADDR_WIDTH-1:0] STRIDE,
    input  logic [CNT_WIDTH-1:0]  COUNT,
    input  logic [DATA_WIDTH-1:0] SEED,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [ERR_WIDTH-1:0]  ERR_COUNT,
    output logic [ADDR_WIDTH-1:0] FIRST_ERR_ADDR,
    mem_pattern_tester_if.master  mem
);

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [CNT_WIDTH-1:0]  idx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            drain_cnt;
    logic                  last;
    logic                  drain_done;
    logic                  start_ok;
    logic [DATA_WIDTH-1:0] pat;

    assign last       = (idx == count_q - CNT_WIDTH'(1));
    assign drain_done = (drain_cnt == 3'(READ_LATENCY - 1));
    assign start_ok   = START && (state == ST_IDLE);
    assign pat        = (seed_q + DATA_WIDTH'(idx)) ^ DATA_WIDTH'(ID);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (START) begin
                    if (COUNT == '0)              state_nxt = ST_FIN;
                    else if (MODE == MODE_READ)   state_nxt = ST_READ;
                    else                          state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mode_q == MODE_INTERLEAVE)    state_nxt = ST_READ;
                else if (last && mode_q == MODE_VERIFY) state_nxt = ST_READ;
                else if (last)                    state_nxt = ST_FIN;
            end
            ST_READ: begin
                if (last)                              state_nxt = ST_DRAIN;
                else if (mode_q == MODE_INTERLEAVE)    state_nxt = ST_WRITE;
            end
            ST_DRAIN: begin
                if (drain_done) state_nxt = ST_FIN;
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address advances by accumulation; interleave mode holds it across the write/read pair.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q    <= MODE_READ;
            base_q    <= '0;
            stride_q  <= '0;
            count_q   <= '0;
            seed_q    <= '0;
            idx       <= '0;
            addr_q    <= '0;
            drain_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (START) begin
                        mode_q    <= MODE;
                        base_q    <= BASE_ADDR;
                        stride_q  <= STRIDE;
                        count_q   <= COUNT;
                        seed_q    <= SEED;
                        idx       <= '0;
                        addr_q    <= BASE_ADDR;
                        drain_cnt <= '0;
                    end
                end
                ST_WRITE: begin
                    if (mode_q != MODE_INTERLEAVE) begin
                        if (last && mode_q == MODE_VERIFY) begin
                            idx    <= '0;
                            addr_q <= base_q;
                        end else begin
                            idx    <= idx + CNT_WIDTH'(1);
                            addr_q <= addr_q + stride_q;
                        end
                    end
                end
                ST_READ: begin
                    if (!last) begin
                        idx    <= idx + CNT_WIDTH'(1);
                        addr_q <= addr_q + stride_q;
                    end
                    drain_cnt <= '0;
                end
                ST_DRAIN: drain_cnt <= drain_cnt + 3'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        BUSY     = 1'b0;
        DONE     = 1'b0;
        mem.ADDR = '0;
        mem.D    = '0;
        mem.WE   = 1'b0;
        mem.RE   = 1'b0;
        mem.BE   = '0;
        unique case (state)
            ST_WRITE: begin
                BUSY     = 1'b1;
                mem.WE   = 1'b1;
                mem.ADDR = addr_q;
                mem.D    = pat;
                mem.BE   = '1;
            end
            ST_READ: begin
                BUSY     = 1'b1;
                mem.RE   = 1'b1;
                mem.ADDR = addr_q;
            end
            ST_DRAIN: BUSY = 1'b1;
            ST_FIN:   DONE = 1'b1;
            default: ;
        endcase
    end

    mem_pattern_checker #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY),
        .ERR_WIDTH    (ERR_WIDTH)
    ) u_checker (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .clear          (start_ok),
        .push_valid     (state == ST_READ),
        .push_data      (pat),
        .push_addr      (addr_q),
        .Q              (mem.Q),
        .ERR_COUNT      (ERR_COUNT),
        .FIRST_ERR_ADDR (FIRST_ERR_ADDR)
    );

endmodule

// File: tb/tb_mem_pattern_tester.sv
// tb/tb_mem_pattern_tester.sv - scoreboard bench for mem_pattern_tester with a latency-accurate memory model
module tb_mem_pattern_tester;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int CW = 16;
    localparam int EW = 2;
    localparam int ID = 3;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START = 1'b0;
    logic [1:0]    MODE = 2'd0;
    logic [AW-1:0] BASE_ADDR = '0;
    logic [AW-1:0] STRIDE = '0;
    logic [CW-1:0] COUNT = '0;
    logic [DW-1:0] SEED = '0;
    logic          BUSY;
    logic          DONE;
    logic [EW-1:0] ERR_COUNT;
    logic [AW-1:0] FIRST_ERR_ADDR;

    mem_pattern_tester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

    mem_pattern_tester #(
        .ID(ID), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .READ_LATENCY(RL), .CNT_WIDTH(CW), .ERR_WIDTH(EW)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .MODE(MODE),
        .BASE_ADDR(BASE_ADDR), .STRIDE(STRIDE), .COUNT(COUNT), .SEED(SEED),
        .BUSY(BUSY), .DONE(DONE), .ERR_COUNT(ERR_COUNT),
        .FIRST_ERR_ADDR(FIRST_ERR_ADDR), .mem(mif)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [DW-1:0] mem_arr [0:65535];
    logic [DW-1:0] rd_pipe [RL];
    bit            mem_zero = 1'b0;
    bit            corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;

    always @(posedge CLK) begin
        if (mif.WE) mem_arr[mif.ADDR] <= mif.D;
        if (mif.RE)
            rd_pipe[0] <= mem_zero ? '0 :
                          (mem_arr[mif.ADDR] ^ ((corrupt_en && mif.ADDR == corrupt_addr) ? 32'h0000_00FF : 32'h0));
        else
            rd_pipe[0] <= '0;
        for (int j = 1; j < RL; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign mif.Q = rd_pipe[RL-1];

    typedef struct {
        int            kind;   // 0 write, 1 read, 2 done
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [EW-1:0] err;
        logic [AW-1:0] ferr;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;
    bit  busy_seen = 1'b0;
    logic [DW-1:0] tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expected event per WE/RE/DONE cycle.
    ev_t ev;
    int  act_kind;
    always @(negedge CLK) begin
        if (RST_N) begin
            if (BUSY) busy_seen = 1'b1;
            if (mif.WE || mif.RE || DONE) begin
                act_kind = DONE ? 2 : (mif.WE ? 0 : 1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output kind=%0d addr=0x%0h (cycle %0d)", act_kind, mif.ADDR, cyc);
                end else begin
                    ev = sb.pop_front();
                    chk("kind", act_kind, ev.kind);
                    chk("cycle", cyc, ev.cyc);
                    if (ev.kind == 2) begin
                        chk("done_err_count", ERR_COUNT, ev.err);
                        chk("done_first_err_addr", FIRST_ERR_ADDR, ev.ferr);
                        chk("done_busy_low", BUSY, 0);
                    end else begin
                        chk("we_re_exclusive", mif.WE & mif.RE, 0);
                        chk("addr", mif.ADDR, ev.addr);
                        chk("be", mif.BE, mif.WE ? 4'hF : 4'h0);
                        chk("busy_high", BUSY, 1);
                        if (ev.kind == 0) chk("wdata", mif.D, ev.data);
                    end
                end
            end
        end
    end

    task automatic push(input int kind, input int c, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [EW-1:0] e, input logic [AW-1:0] f,
                        input int stop);
        ev_t x;
        if (c < stop) begin
            x.kind = kind; x.cyc = c; x.addr = a; x.data = d; x.err = e; x.ferr = f;
            sb.push_back(x);
        end
    endtask

    task automatic expect_run(input int mode, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                              input int count, input logic [DW-1:0] seed, input int s,
                              input logic [EW-1:0] e, input logic [AW-1:0] f,
                              input bit use_tbl, input int stop);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (count == 0) begin
            push(2, s + 1, '0, '0, e, f, stop);
            return;
        end
        if (mode == 2) begin
            for (int i = 0; i < count; i++) begin
                a = AW'(int'(base) + i * int'(stride));
                d = use_tbl ? tbl[i] : ((seed + DW'(i)) ^ DW'(ID));
                push(0, s + 1 + i, a, d, e, f, stop);
            end
        end
        for (int i = 0; i < count; i++) begin
            a = AW'(int'(base) + i * int'(stride));
            d = use_tbl ? tbl[i] : ((seed + DW'(i)) ^ DW'(ID));
            case (mode)
                0: push(1, s + 1 + i, a, d, e, f, stop);
                1: push(0, s + 1 + i, a, d, e, f, stop);
                2: push(1, s + 1 + count + i, a, d, e, f, stop);
                default: begin
                    push(0, s + 1 + 2 * i, a, d, e, f, stop);
                    push(1, s + 2 + 2 * i, a, d, e, f, stop);
                end
            endcase
        end
        case (mode)
            0: push(2, s + 1 + count + RL, '0, '0, e, f, stop);
            1: push(2, s + 1 + count, '0, '0, e, f, stop);
            default: push(2, s + 2 * count + 1 + RL, '0, '0, e, f, stop);
        endcase
    endtask

    task automatic drive_start(input int mode, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                               input int count, input logic [DW-1:0] seed);
        MODE = 2'(mode); BASE_ADDR = base; STRIDE = stride; COUNT = CW'(count); SEED = seed;
        START = 1'b1;
    endtask

    task automatic run(input int mode, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                       input int count, input logic [DW-1:0] seed,
                       input logic [EW-1:0] e, input logic [AW-1:0] f, input bit use_tbl);
        int  s;
        bit  done_seen;
        @(posedge CLK); #1;
        drive_start(mode, base, stride, count, seed);
        s = cyc;
        busy_seen = 1'b0;
        expect_run(mode, base, stride, count, seed, s, e, f, use_tbl, 32'h7fff_ffff);
        @(posedge CLK); #1;
        START = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (DONE) begin
                START = 1'b1;       // lands in FIN and must be ignored
                done_seen = 1'b1;
                break;
            end
            START = (cyc == s + 3); // lands mid-run and must be ignored
            @(posedge CLK); #1;
        end
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done mode=%0d", mode);
        end
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        chk("err_count_held", ERR_COUNT, e);
        chk("first_err_addr_held", FIRST_ERR_ADDR, f);
        chk("idle_busy_low", BUSY, 0);
        if (count == 0) chk("count0_busy_never", busy_seen, 0);
        sb.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"}, mif.WE, 0);
        chk({tag, "_re"}, mif.RE, 0);
        chk({tag, "_be"}, mif.BE, 0);
        chk({tag, "_addr"}, mif.ADDR, 0);
        chk({tag, "_d"}, mif.D, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_err"}, ERR_COUNT, 0);
        chk({tag, "_ferr"}, FIRST_ERR_ADDR, 0);
    endtask

    initial begin
        int s;
        for (int i = 0; i < 65536; i++) mem_arr[i] = '0;
        for (int j = 0; j < RL; j++) rd_pipe[j] = '0;
        tbl[0] = 32'h1003; tbl[1] = 32'h1002; tbl[2] = 32'h1001; tbl[3] = 32'h1000;
        tbl[4] = 32'h1007; tbl[5] = 32'h1006; tbl[6] = 32'h1005; tbl[7] = 32'h1004;

        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        RST_N = 1'b1;

        // Fill-then-verify with hand-tabulated data words
        run(2, 16'h0100, 16'h0004, 8, 32'h1000, 2'd0, 16'h0000, 1'b1);

        // Same run, word at 0x0108 corrupted on read
        corrupt_en = 1'b1; corrupt_addr = 16'h0108;
        run(2, 16'h0100, 16'h0004, 8, 32'h1000, 2'd1, 16'h0108, 1'b1);
        corrupt_en = 1'b0;

        // COUNT==0 in two modes; also clears the previous error
        run(2, 16'h0100, 16'h0004, 0, 32'h1000, 2'd0, 16'h0000, 1'b0);
        run(0, 16'h0300, 16'h0004, 0, 32'h1000, 2'd0, 16'h0000, 1'b0);

        // Interleaved with address wrap: 0004, 0000, FFFC
        run(3, 16'h0004, 16'hFFFC, 3, 32'hABCD_0000, 2'd0, 16'h0000, 1'b0);

        // Fill then plain read sweep, seed wraps through zero
        run(1, 16'h0400, 16'h0008, 5, 32'hFFFF_FFFE, 2'd0, 16'h0000, 1'b0);
        run(0, 16'h0400, 16'h0008, 5, 32'hFFFF_FFFE, 2'd0, 16'h0000, 1'b0);

        // Reset in the middle of the read phase
        @(posedge CLK); #1;
        drive_start(2, 16'h0100, 16'h0004, 8, 32'h2000);
        s = cyc;
        expect_run(2, 16'h0100, 16'h0004, 8, 32'h2000, s, 2'd0, 16'h0000, 1'b0, s + 12);
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (11) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        chk("reset_scoreboard_drained", sb.size(), 0);
        sb.delete();
        run(2, 16'h0100, 16'h0004, 8, 32'h2000, 2'd0, 16'h0000, 1'b0);

        // Error storm saturates the 2-bit count, then a clean run clears it
        mem_zero = 1'b1;
        run(0, 16'h0200, 16'h0004, 8, 32'h0000_0055, 2'd3, 16'h0200, 1'b0);
        mem_zero = 1'b0;
        run(2, 16'h0200, 16'h0004, 8, 32'h0000_0055, 2'd0, 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
